ts4231_config_scheduler: RTL and testbench

Shares one `ts4231Configurator` instance between `N_SENSORS` TS4231 light sensors and decides when each sensor is configured. On a start request, and optionally when a sensor goes silent, it queues sensors, grants them round-robin, routes the granted sensor's D/E pins to the configurator, and pulses its `reconfigure` input. It detects completion or timeout and retries up to a limit. It sits between the sensor I/O pads and the single configurator, ahead of the pulse-timing datapath.

---
 rtl/ts4231_pkg.sv | 18 +
 rtl/ts4231_config_scheduler_rr_pick.sv | 30 +++
 rtl/ts4231_config_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_ts4231_config_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ts4231_pkg.sv
// Shared types and 96 MHz default timing constants for the TS4231 configuration scheduler.
package ts4231_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ARM,
    S_WAIT,
    S_GAP
  } sched_state_t;

  localparam int DEF_ARM_CYCLES      = 256;
  localparam int DEF_GAP_CYCLES      = 256;
  localparam int DEF_TIMEOUT_CYCLES  = 9_600_000;
  localparam int DEF_MAX_RETRY       = 3;
  localparam int DEF_WATCHDOG_CYCLES = 4_800_000;

endpackage

// File: rtl/ts4231_config_scheduler_rr_pick.sv
// Round-robin picker: lowest pending index strictly after last_idx, wrapping around.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] last_idx,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  logic [IW:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest pending one wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, last_idx} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (pending[cand[IW-1:0]]) begin
        idx   = cand[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ts4231_config_scheduler.sv
// Shares one ts4231Configurator between N_SENSORS sensors: queues, grants round-robin, routes pins, retries.
// Optional envelope-silence watchdog re-queuing is enabled by defining TS4231_WATCHDOG_EN.
module ts4231_config_scheduler
  import ts4231_pkg::*;
#(
  parameter int N_SENSORS       = 4,
  parameter int ARM_CYCLES      = DEF_ARM_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY       = DEF_MAX_RETRY,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N_SENSORS-1:0]         s_d_in,
  input  logic [N_SENSORS-1:0]         s_e_in,
  output logic [N_SENSORS-1:0]         s_d_out,
  output logic [N_SENSORS-1:0]         s_d_oe,
  output logic [N_SENSORS-1:0]         s_e_out,
  output logic [N_SENSORS-1:0]         s_e_oe,
  output logic                         cfg_d_in,
  output logic                         cfg_e_in,
  input  logic                         cfg_d_out,
  input  logic                         cfg_d_oe,
  input  logic                         cfg_e_out,
  input  logic                         cfg_e_oe,
  output logic                         cfg_reconfigure,
  output logic [N_SENSORS-1:0]         configured,
  output logic [N_SENSORS-1:0]         fault,
  output logic                         busy,
  output logic [$clog2(N_SENSORS)-1:0] active_idx
);

  localparam int IW = $clog2(N_SENSORS);
  localparam int RW = $clog2(MAX_RETRY + 1);

  sched_state_t state, state_d;

  logic                 start_q, start_rise;
  logic [N_SENSORS-1:0] pending, pending_d, configured_d, fault_d, wd_expire;
  logic [RW-1:0]        retry [N_SENSORS];
  logic [RW-1:0]        retry_next;
  logic                 retry_inc, retry_clr;
  logic [IW-1:0]        last_idx, pick_idx;
  logic                 pick_valid;
  logic [31:0]          phase_cnt, timer;
  logic                 e_oe_seen, e_oe_q, requeue;
  logic                 done, timed_out;

  rr_pick #(.N(N_SENSORS)) u_pick (
    .pending  (pending),
    .last_idx (last_idx),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  assign start_rise = start & ~start_q;
  assign busy       = (state != S_IDLE);
  assign done       = e_oe_seen & e_oe_q & ~cfg_e_oe;
  assign timed_out  = (timer == 32'(TIMEOUT_CYCLES));
  assign retry_next = retry[active_idx] + RW'(1);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (pending != '0) state_d = S_SELECT;
      S_SELECT: state_d = pick_valid ? S_ARM : S_IDLE;
      S_ARM:    if (phase_cnt == 32'(ARM_CYCLES - 1)) state_d = S_WAIT;
      S_WAIT:   if (done || timed_out) state_d = S_GAP;
      S_GAP:    if (phase_cnt == 32'(GAP_CYCLES - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Completion beats timeout; a start seen during the grant keeps the active sensor queued.
  always_comb begin
    pending_d    = pending;
    configured_d = configured;
    fault_d      = fault;
    retry_inc    = 1'b0;
    retry_clr    = 1'b0;
    if (state == S_WAIT) begin
      if (done) begin
        configured_d[active_idx] = 1'b1;
        pending_d[active_idx]    = requeue;
        retry_clr                = 1'b1;
      end else if (timed_out) begin
        retry_inc = 1'b1;
        if (retry_next == RW'(MAX_RETRY)) begin
          fault_d[active_idx]   = 1'b1;
          pending_d[active_idx] = 1'b0;
        end
      end
    end
    if (start_rise) begin
      pending_d    = pending_d | ~fault_d;
      configured_d = configured_d & fault_d;
    end
    pending_d    = pending_d | wd_expire;
    configured_d = configured_d & ~wd_expire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      start_q         <= 1'b0;
      pending         <= '0;
      configured      <= '0;
      fault           <= '0;
      last_idx        <= IW'(N_SENSORS - 1);
      active_idx      <= '0;
      phase_cnt       <= '0;
      timer           <= '0;
      e_oe_seen       <= 1'b0;
      e_oe_q          <= 1'b0;
      requeue         <= 1'b0;
      cfg_reconfigure <= 1'b0;
      for (int i = 0; i < N_SENSORS; i++) retry[i] <= '0;
    end else begin
      state           <= state_d;
      start_q         <= start;
      e_oe_q          <= cfg_e_oe;
      cfg_reconfigure <= (state_d == S_ARM);
      pending         <= pending_d;
      configured      <= configured_d;
      fault           <= fault_d;
      if (state_d != state) phase_cnt <= '0;
      else if (state == S_ARM || state == S_GAP) phase_cnt <= phase_cnt + 32'd1;
      if (retry_clr) retry[active_idx] <= '0;
      else if (retry_inc) retry[active_idx] <= retry_next;
      case (state)
        S_SELECT: begin
          if (pick_valid) active_idx <= pick_idx;
          timer     <= '0;
          e_oe_seen <= 1'b0;
          requeue   <= start_rise;
        end
        S_ARM, S_WAIT: begin
          if (!timed_out) timer <= timer + 32'd1;
          if (cfg_e_oe) e_oe_seen <= 1'b1;
          if (start_rise) requeue <= 1'b1;
        end
        S_GAP: if (state_d == S_IDLE) last_idx <= active_idx;
        default: ;
      endcase
    end
  end

  always_comb begin
    s_d_out  = '0;
    s_d_oe   = '0;
    s_e_out  = '0;
    s_e_oe   = '0;
    cfg_d_in = 1'b0;
    cfg_e_in = 1'b1;
    if (busy) begin
      cfg_d_in            = s_d_in[active_idx];
      cfg_e_in            = s_e_in[active_idx];
      s_d_out[active_idx] = cfg_d_out;
      s_d_oe[active_idx]  = cfg_d_oe;
      s_e_out[active_idx] = cfg_e_out;
      s_e_oe[active_idx]  = cfg_e_oe;
    end
  end

`ifdef TS4231_WATCHDOG_EN
  logic [N_SENSORS-1:0] e_sync1, e_sync2, e_sync3;
  logic [31:0]          wd_cnt [N_SENSORS];

  // A silent envelope on a configured, ungranted sensor means it lost its configuration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_sync1 <= '0;
      e_sync2 <= '0;
      e_sync3 <= '0;
      for (int i = 0; i < N_SENSORS; i++) wd_cnt[i] <= '0;
    end else begin
      e_sync1 <= s_e_in;
      e_sync2 <= e_sync1;
      e_sync3 <= e_sync2;
      for (int i = 0; i < N_SENSORS; i++) begin
        if (wd_expire[i] || (e_sync3[i] && !e_sync2[i])) wd_cnt[i] <= '0;
        else if (configured[i] && !(busy && active_idx == IW'(i))) wd_cnt[i] <= wd_cnt[i] + 32'd1;
      end
    end
  end

  always_comb begin
    wd_expire = '0;
    for (int i = 0; i < N_SENSORS; i++) wd_expire[i] = (wd_cnt[i] == 32'(WATCHDOG_CYCLES));
  end
`else
  logic wd_unused;
  assign wd_unused = (WATCHDOG_CYCLES != 0);
  assign wd_expire = '0;
`endif

endmodule

// File: tb/tb_ts4231_config_scheduler.sv
// Scoreboard bench for ts4231_config_scheduler with a behavioural configurator model.
`timescale 1ns/1ps
module tb_ts4231_config_scheduler;

  localparam int N        = 4;
  localparam int ARM      = 64;
  localparam int GAP      = 64;
  localparam int TMO      = 5000;
  localparam int RETRY    = 3;
  localparam int WD       = 10000;
  localparam int DONE_CYC = 400;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] s_d_in = '1;
  logic [N-1:0] s_e_in;
  logic [N-1:0] s_d_out, s_d_oe, s_e_out, s_e_oe, configured, fault;
  logic         cfg_d_in, cfg_e_in, cfg_reconfigure, busy;
  logic         cfg_d_out = 1'b0, cfg_d_oe = 1'b0, cfg_e_out = 1'b0, cfg_e_oe = 1'b0;
  logic [1:0]   active_idx;

  int           n_checks = 0;
  int           n_fail = 0;
  int           exp_q[$];
  logic         mon_en = 1'b0;
  logic [N-1:0] e_phase = '0;
  logic [N-1:0] e_toggle = '1;

  assign s_e_in = e_phase | ~e_toggle;

  always #5 clk = ~clk;

  ts4231_config_scheduler #(
    .N_SENSORS(N), .ARM_CYCLES(ARM), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY(RETRY), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_d_in(s_d_in), .s_e_in(s_e_in),
    .s_d_out(s_d_out), .s_d_oe(s_d_oe), .s_e_out(s_e_out), .s_e_oe(s_e_oe),
    .cfg_d_in(cfg_d_in), .cfg_e_in(cfg_e_in),
    .cfg_d_out(cfg_d_out), .cfg_d_oe(cfg_d_oe), .cfg_e_out(cfg_e_out), .cfg_e_oe(cfg_e_oe),
    .cfg_reconfigure(cfg_reconfigure),
    .configured(configured), .fault(fault), .busy(busy), .active_idx(active_idx)
  );

  // Configurator model: after reconfigure falls, drives E for DONE_CYC clocks if the sensor answers on D.
  int m_state = 0;
  int m_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_state <= 0; m_cnt <= 0;
      cfg_e_oe <= 1'b0; cfg_d_oe <= 1'b0; cfg_e_out <= 1'b0; cfg_d_out <= 1'b0;
    end else begin
      case (m_state)
        0: if (cfg_reconfigure) m_state <= 1;
        1: if (!cfg_reconfigure) begin
             if (cfg_d_in) begin
               m_state <= 2; m_cnt <= 0; cfg_e_oe <= 1'b1; cfg_d_oe <= 1'b1;
             end else m_state <= 0;
           end
        default: begin
          m_cnt     <= m_cnt + 1;
          cfg_e_out <= ~cfg_e_out;
          cfg_d_out <= m_cnt[1];
          if (m_cnt == DONE_CYC - 1) begin
            m_state <= 0;
            cfg_e_oe <= 1'b0; cfg_d_oe <= 1'b0; cfg_e_out <= 1'b0; cfg_d_out <= 1'b0;
          end
        end
      endcase
    end
  end

  initial begin
    forever begin
      repeat (100) @(posedge clk);
      #1 e_phase = ~e_phase;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkAtLeast(input string name, input int act, input int req);
    n_checks++;
    if (act < req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0d required>=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] alive, input logic chk_lat);
    s_d_in = alive;
    start  = 1'b1;
    tick(1);
    if (chk_lat) checkOutput("busy_after_1clk", 32'(busy), 0);
    tick(1);
    if (chk_lat) checkOutput("busy_after_2clk", 32'(busy), 1);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 4; i++) begin
      tick(1);
      if (!busy) quiet++; else quiet = 0;
    end
    checkOutput({name, "_idle"}, 32'(quiet >= 4), 1);
  endtask

  task automatic waitReconf(input string name, input logic level, input int budget);
    for (int i = 0; i < budget && cfg_reconfigure !== level; i++) tick(1);
    checkOutput(name, 32'(cfg_reconfigure), 32'(level));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_configured"}, 32'(configured), 0);
    checkOutput({tag, "_fault"}, 32'(fault), 0);
    checkOutput({tag, "_reconf"}, 32'(cfg_reconfigure), 0);
    checkOutput({tag, "_cfg_e_in"}, 32'(cfg_e_in), 1);
    checkOutput({tag, "_cfg_d_in"}, 32'(cfg_d_in), 0);
    checkOutput({tag, "_active_idx"}, 32'(active_idx), 0);
    checkOutput({tag, "_pads"}, 32'({s_d_out, s_d_oe, s_e_out, s_e_oe}), 0);
  endtask

  // Monitor: pops the expected grant on every arm, checks arm spacing and pad routing each cycle.
  initial begin : monitor
    logic         prev_rc = 1'b0;
    int           low_cnt = 1000;
    int           g = 0;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cfg_reconfigure && !prev_rc) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_arm_idx", 32'(active_idx), 32'hFFFF);
          end else begin
            g = exp_q.pop_front();
            checkOutput("grant_idx", 32'(active_idx), 32'(g));
          end
          checkAtLeast("reconf_low_gap", low_cnt, GAP);
          low_cnt = 0;
        end
        if (!cfg_reconfigure) low_cnt++;
        oh = N'(1) << g;
        checkOutput("pad_routing", 32'({s_d_out, s_d_oe, s_e_out, s_e_oe}),
                    32'({cfg_d_out ? oh : '0, cfg_d_oe ? oh : '0, cfg_e_out ? oh : '0, cfg_e_oe ? oh : '0}));
        prev_rc = cfg_reconfigure;
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    n_fail++;
    $display("[TB] FAIL global_timeout: actual=running required=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    tick(3);
    mon_en = 1'b1;
    checkResetState("reset");
    rst_n = 1'b1;
    tick(5);

    $display("[TB] scan all four sensors");
    exp_q = '{0, 1, 2, 3};
    applyStimulus(4'b1111, 1'b1);
    waitIdle("scan_all", 5000);
    checkOutput("scan_all_configured", 32'(configured), 32'hF);
    checkOutput("scan_all_fault", 32'(fault), 0);
    checkOutput("scan_all_queue", 32'(exp_q.size()), 0);

    $display("[TB] sensor 2 never answers");
    exp_q = '{0, 1, 2, 3, 2, 2};
    applyStimulus(4'b1011, 1'b1);
    waitIdle("timeout", 25000);
    checkOutput("timeout_configured", 32'(configured), 32'hB);
    checkOutput("timeout_fault", 32'(fault), 32'h4);
    checkOutput("timeout_queue", 32'(exp_q.size()), 0);

    $display("[TB] start re-pulsed while sensor 1 waits");
    exp_q = '{3, 0, 1, 3, 0, 1};
    applyStimulus(4'b1011, 1'b1);
    for (int a = 0; a < 3; a++) begin
      waitReconf("rescan_arm_hi", 1'b1, 3000);
      waitReconf("rescan_arm_lo", 1'b0, 3000);
    end
    tick(50);
    checkOutput("rescan_mid_busy", 32'(busy), 1);
    checkOutput("rescan_mid_configured", 32'(configured), 32'h9);
    applyStimulus(4'b1011, 1'b0);
    checkOutput("rescan_requeue_clears", 32'(configured), 0);
    waitIdle("rescan", 8000);
    checkOutput("rescan_configured", 32'(configured), 32'hB);
    checkOutput("rescan_fault", 32'(fault), 32'h4);
    checkOutput("rescan_queue", 32'(exp_q.size()), 0);

    $display("[TB] reset in the middle of ARM");
    exp_q = '{3};
    applyStimulus(4'b1011, 1'b1);
    waitReconf("midarm_arm_hi", 1'b1, 100);
    tick(10);
    rst_n = 1'b0;
    tick(1);
    checkResetState("midarm");
    tick(3);
    rst_n = 1'b1;
    tick(100);
    exp_q = '{0, 1, 2, 3};
    applyStimulus(4'b1111, 1'b1);
    waitIdle("after_reset", 5000);
    checkOutput("after_reset_configured", 32'(configured), 32'hF);
    checkOutput("after_reset_fault", 32'(fault), 0);
    checkOutput("after_reset_queue", 32'(exp_q.size()), 0);

    $display("[TB] sensor 3 envelope goes silent");
    e_toggle = 4'b0111;
`ifdef TS4231_WATCHDOG_EN
    exp_q = '{3};
    for (int i = 0; i < WD + 1000 && configured[3] !== 1'b0; i++) tick(1);
    checkOutput("wd_cfg3_cleared", 32'(configured[3]), 0);
    waitIdle("wd_rescan", 3000);
    checkOutput("wd_configured", 32'(configured), 32'hF);
    checkOutput("wd_queue", 32'(exp_q.size()), 0);
`else
    tick(WD + 5000);
    checkOutput("nowd_configured", 32'(configured), 32'hF);
    checkOutput("nowd_busy", 32'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
